// File: rtl/ifft_tile_crop_if.sv
// Tile-crop bus: IFFT tile input side and cropped-row output side.
interface ifft_tile_crop_if #(
  parameter int unsigned DATALEN = 16,
  parameter int unsigned FFTCHNL = 8,
  parameter int unsigned KERN    = 3,
  parameter int unsigned OUTLEN  = 8
);
  localparam int unsigned VR = FFTCHNL - KERN + 1;

  logic                         in_next;
  logic [FFTCHNL*4*DATALEN-1:0] in_data;
  logic                         relu_en;
  logic                         out_valid;
  logic                         out_ready;
  logic [VR*OUTLEN-1:0]         out_data;
  logic                         out_last;
  logic                         overflow;

  modport slave (
    input  in_next, in_data, relu_en, out_ready,
    output out_valid, out_data, out_last, overflow
  );

  modport master (
    output in_next, in_data, relu_en, out_ready,
    input  out_valid, out_data, out_last, overflow
  );
endinterface

// File: rtl/ifft_tile_crop.sv
// Requantizes 2D IFFT tiles, keeps the overlap-save valid window and
// streams it row by row through a two-tile ping-pong buffer.
module ifft_tile_crop #(
  parameter int unsigned DATALEN = 16,
  parameter int unsigned FFTCHNL = 8,
  parameter int unsigned KERN    = 3,
  parameter int unsigned OUTLEN  = 8,
  parameter int unsigned SHIFT   = 6
) (
  input  logic               clk,
  input  logic               rstn,
  ifft_tile_crop_if.slave    bus
);
  localparam int unsigned VR    = FFTCHNL - KERN + 1;
  localparam int unsigned BEATS = FFTCHNL / 2;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned RW    = (VR > 1) ? $clog2(VR) : 1;
  localparam int unsigned SW    = DATALEN + 1;
  localparam int unsigned CW    = 4 * DATALEN;
  localparam int unsigned ROWW  = VR * OUTLEN;

  localparam logic        [SW-1:0] RND     = SW'(1) << (SHIFT - 1);
  localparam logic signed [SW-1:0] SAT_MAX = SW'((1 << (OUTLEN - 1)) - 1);
  localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_CAP  = 1'b1;

  // Round-half-up, arithmetic shift, saturate, optional ReLU.
  function automatic logic [OUTLEN-1:0] requant(input logic [DATALEN-1:0] x, input logic relu);
    logic signed [SW-1:0] s;
    s = $signed({x[DATALEN-1], x} + RND);
    s = s >>> SHIFT;
    if (s > SAT_MAX)      s = SAT_MAX;
    else if (s < SAT_MIN) s = SAT_MIN;
    if (relu && s[SW-1])  s = '0;
    return OUTLEN'(s);
  endfunction

  // off selects the real word of point 0 (0) or point 1 (2) in each column slice.
  function automatic logic [ROWW-1:0] crop_row(input logic [FFTCHNL*CW-1:0] d,
                                               input int unsigned off, input logic relu);
    logic [ROWW-1:0] r;
    r = '0;
    for (int unsigned j = 0; j < VR; j++)
      r[j*OUTLEN +: OUTLEN] = requant(d[(j + KERN - 1)*CW + off*DATALEN +: DATALEN], relu);
    return r;
  endfunction

  logic [0:0]      state, state_n;
  logic [BW-1:0]   beat, beat_n;
  logic            cap_relu, cap_relu_n;
  logic            wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
  logic [1:0]      count, count_n;
  logic [RW-1:0]   rd_row, rd_row_n;
  logic            ovf_n, valid_n, last_n;
  logic [ROWW-1:0] data_n;
  logic [ROWW-1:0] mem [2][VR];
  logic [ROWW-1:0] q0, q1;
  logic            last_beat, accept, fire, free, byp;
  logic            w_en0, w_en1;
  logic [RW-1:0]   w_idx0, w_idx1;
  int unsigned     r0, sel_row;
  logic            unused_in;

  // Quantized cropped rows carried by the current beat.
  always_comb begin
    q0        = crop_row(bus.in_data, 0, cap_relu);
    q1        = crop_row(bus.in_data, 2, cap_relu);
    unused_in = ^bus.in_data;
    r0        = 32'(beat) * 2;
    w_en0     = (state == ST_CAP) && (r0 >= KERN - 1);
    w_en1     = (state == ST_CAP) && (r0 + 1 >= KERN - 1);
    w_idx0    = RW'(r0 - (KERN - 1));
    w_idx1    = RW'(r0 + 1 - (KERN - 1));
  end

  always_comb begin
    state_n    = state;
    beat_n     = beat;
    cap_relu_n = cap_relu;
    wr_ptr_n   = wr_ptr;
    rd_ptr_n   = rd_ptr;
    count_n    = count;
    rd_row_n   = rd_row;
    ovf_n      = bus.overflow;
    valid_n    = 1'b0;
    last_n     = 1'b0;
    data_n     = '0;
    accept     = 1'b0;
    byp        = 1'b0;
    sel_row    = 0;
    last_beat  = (state == ST_CAP) && (beat == BW'(BEATS - 1));

    // A tile still being captured owns a buffer, so it counts against free space.
    if (bus.in_next) begin
      if (((state == ST_CAP) && (!last_beat || count != 2'd0)) || count == 2'd2)
        ovf_n = 1'b1;
      else
        accept = 1'b1;
    end

    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_n    = ST_CAP;
          beat_n     = '0;
          cap_relu_n = bus.relu_en;
        end
      end
      ST_CAP: begin
        beat_n = beat + 1'b1;
        if (last_beat) begin
          wr_ptr_n = ~wr_ptr;
          beat_n   = '0;
          if (accept) cap_relu_n = bus.relu_en;
          else        state_n    = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    fire = bus.out_valid && bus.out_ready;
    free = fire && (rd_row == RW'(VR - 1));
    if (fire) begin
      if (free) begin
        rd_row_n = '0;
        rd_ptr_n = ~rd_ptr;
      end else begin
        rd_row_n = rd_row + 1'b1;
      end
    end
    count_n = count + {1'b0, last_beat} - {1'b0, free};

    // Row landing in the buffer on this same edge is forwarded from the input.
    sel_row = 32'(rd_row_n) + KERN - 1;
    byp     = (state == ST_CAP) && (rd_ptr_n == wr_ptr) && ((sel_row >> 1) == 32'(beat));
    valid_n = (count_n != 2'd0);
    if (valid_n) begin
      last_n = (rd_row_n == RW'(VR - 1));
      data_n = byp ? (sel_row[0] ? q1 : q0) : mem[rd_ptr_n][rd_row_n];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= ST_IDLE;
      beat          <= '0;
      cap_relu      <= 1'b0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      count         <= '0;
      rd_row        <= '0;
      bus.overflow  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_data  <= '0;
    end else begin
      state         <= state_n;
      beat          <= beat_n;
      cap_relu      <= cap_relu_n;
      wr_ptr        <= wr_ptr_n;
      rd_ptr        <= rd_ptr_n;
      count         <= count_n;
      rd_row        <= rd_row_n;
      bus.overflow  <= ovf_n;
      bus.out_valid <= valid_n;
      bus.out_last  <= last_n;
      bus.out_data  <= data_n;
    end
  end

  // Tile storage; contents are don't-care until a full tile is marked.
  always_ff @(posedge clk) begin
    if (w_en0) mem[wr_ptr][w_idx0] <= q0;
    if (w_en1) mem[wr_ptr][w_idx1] <= q1;
  end
endmodule

// File: tb/tb_ifft_tile_crop.sv
// Bench for ifft_tile_crop: quantization vector table, crop map, streaming,
// backpressure/overflow, random traffic and mid-capture reset.
module tb_ifft_tile_crop;
  localparam int unsigned DL = 16, FC = 8, KN = 3, OL = 8, SH = 6;
  localparam int unsigned VR = FC - KN + 1;
  localparam int unsigned CW = 4 * DL;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  ifft_tile_crop_if #(.DATALEN(DL), .FFTCHNL(FC), .KERN(KN), .OUTLEN(OL)) bus ();
  ifft_tile_crop #(.DATALEN(DL), .FFTCHNL(FC), .KERN(KN), .OUTLEN(OL), .SHIFT(SH))
    dut (.clk(clk), .rstn(rstn), .bus(bus));

  typedef struct { logic [VR*OL-1:0] data; logic last; int avail; } row_t;
  typedef struct { logic [DL-1:0] x; bit relu; logic [OL-1:0] y; } qvec_t;

  row_t           exp_q[$];
  int             errors = 0, checks = 0, cyc = 0;
  logic [DL-1:0]  tre [4][FC][FC];
  int             starts[4];
  bit             relus[4];
  int             accepted, freed, acc_start, acc_slot, first_drop, rows_seen;
  bit             mon_en = 1'b0, prev_stall;
  logic [VR*OL-1:0] first_hs, last_hs, prev_data;
  logic           prev_last;
  int             rdy_mode = 0, rdy_until = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Reference requantizer: floor((x + 32) / 64) with saturation and ReLU.
  function automatic logic [OL-1:0] ref_q(input logic [DL-1:0] x, input bit relu);
    int v, n, y, d;
    d = 1 << SH;
    v = int'($signed(x));
    n = v + d / 2;
    y = (n >= 0) ? n / d : -((-n + d - 1) / d);
    if (y > 127)  y = 127;
    if (y < -128) y = -128;
    if (relu && y < 0) y = 0;
    return OL'(y);
  endfunction

  function automatic logic [VR*OL-1:0] ref_row(input int k, input int r);
    logic [VR*OL-1:0] v;
    for (int j = 0; j < VR; j++) v[j*OL +: OL] = ref_q(tre[k][r][j + KN - 1], relus[k]);
    return v;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    accepted = 0; freed = 0; acc_start = -1; acc_slot = 0; first_drop = -1;
    prev_stall = 1'b0; rows_seen = 0;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor against the expected-row queue.
  always @(negedge clk) begin
    bit ev;
    if (mon_en) begin
      ev = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
      check("out_valid", 64'(bus.out_valid), 64'(ev));
      check("overflow", 64'(bus.overflow), 64'(first_drop >= 0 && first_drop < cyc));
      if (prev_stall) begin
        check("hold_data", 64'(bus.out_data), 64'(prev_data));
        check("hold_last", 64'(bus.out_last), 64'(prev_last));
      end
      if (bus.out_valid && ev) begin
        check("row_data", 64'(bus.out_data), 64'(exp_q[0].data));
        check("row_last", 64'(bus.out_last), 64'(exp_q[0].last));
        if (bus.out_ready) begin
          rows_seen++;
          if (rows_seen == 1) first_hs = bus.out_data;
          last_hs = bus.out_data;
          if (exp_q[0].last) freed++;
          void'(exp_q.pop_front());
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_last  = bus.out_last;
    end
  end

  task automatic fill_rand(input int k);
    for (int r = 0; r < FC; r++)
      for (int c = 0; c < FC; c++) tre[k][r][c] = 16'($urandom_range(0, 16383)) - 16'd8192;
  endtask

  task automatic run(input int nt, input int ncyc, input bit chk_drain);
    for (int c = 0; c < ncyc; c++) begin
      logic [FC*CW-1:0] d;
      bit nxt, rl, inwin;
      int off, b;
      @(posedge clk); #1;
      for (int w = 0; w < FC*CW/32; w++) d[w*32 +: 32] = $urandom();
      rl  = 1'($urandom_range(0, 1));
      nxt = 1'b0;
      off = cyc - acc_start;
      if (acc_start >= 0 && off >= 1 && off <= FC/2) begin
        b = off - 1;
        for (int col = 0; col < FC; col++) begin
          d[col*CW +: DL]        = tre[acc_slot][2*b][col];
          d[col*CW + 2*DL +: DL] = tre[acc_slot][2*b + 1][col];
        end
      end
      for (int k = 0; k < nt; k++) begin
        if (starts[k] == cyc) begin
          nxt   = 1'b1;
          rl    = relus[k];
          inwin = (acc_start < 0) || (cyc - acc_start >= FC/2);
          if (!inwin || (accepted - freed) >= 2) begin
            if (first_drop < 0) first_drop = cyc;
          end else begin
            accepted++;
            acc_start = cyc;
            acc_slot  = k;
            for (int r = KN - 1; r < FC; r++)
              exp_q.push_back('{ref_row(k, r), (r == FC - 1), cyc + FC/2 + 1});
          end
        end
      end
      bus.in_next = nxt;
      bus.relu_en = rl;
      bus.in_data = d;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = (cyc >= rdy_until);
      endcase
    end
    bus.in_next = 1'b0;
    if (chk_drain) check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  qvec_t qtab[10];

  initial begin
    qtab[0] = '{16'h0100, 1'b0, 8'h04};
    qtab[1] = '{16'h7FFF, 1'b0, 8'h7F};
    qtab[2] = '{16'h8000, 1'b0, 8'h80};
    qtab[3] = '{16'h0020, 1'b0, 8'h01};
    qtab[4] = '{16'h001F, 1'b0, 8'h00};
    qtab[5] = '{16'hFFC0, 1'b1, 8'h00};
    qtab[6] = '{16'hFFC0, 1'b0, 8'hFF};
    qtab[7] = '{16'hFFE0, 1'b0, 8'h00};
    qtab[8] = '{16'hFFDF, 1'b0, 8'hFF};
    qtab[9] = '{16'h0060, 1'b1, 8'h02};

    bus.in_next = 1'b0; bus.in_data = '0; bus.relu_en = 1'b0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_last", 64'(bus.out_last), 64'd0);
    check("rst_ovf", 64'(bus.overflow), 64'd0);
    check("rst_data", 64'(bus.out_data), 64'd0);
    @(negedge clk) rstn = 1'b1;
    model_reset();
    mon_en = 1'b1;

    // Quantization vectors: whole tile of one value.
    for (int i = 0; i < 10; i++) begin
      for (int r = 0; r < FC; r++) for (int c = 0; c < FC; c++) tre[0][r][c] = qtab[i].x;
      relus[0] = qtab[i].relu; starts[0] = cyc + 2; rows_seen = 0; rdy_mode = 0;
      run(1, 16, 1'b1);
      check("qvec_rows", 64'(rows_seen), 64'd6);
      check("qvec_value", 64'(last_hs), 64'({VR{qtab[i].y}}));
    end

    // Crop map: value row*16+col survives the shift exactly.
    for (int r = 0; r < FC; r++) for (int c = 0; c < FC; c++) tre[0][r][c] = 16'((r*16 + c) << SH);
    relus[0] = 1'b0; starts[0] = cyc + 2; rows_seen = 0;
    run(1, 16, 1'b1);
    check("crop_first", 64'(first_hs), 64'h272625242322);
    check("crop_last", 64'(last_hs), 64'h777675747372);

    // Streaming: second tile on last beat of first, third right after a free.
    for (int k = 0; k < 3; k++) begin fill_rand(k); relus[k] = 1'($urandom_range(0, 1)); end
    starts[0] = cyc + 2; starts[1] = starts[0] + 4; starts[2] = starts[0] + 11; rows_seen = 0;
    run(3, 34, 1'b1);
    check("stream_rows", 64'(rows_seen), 64'd18);
    check("stream_ovf", 64'(bus.overflow), 64'd0);

    // Backpressure: two tiles held, third dropped.
    for (int k = 0; k < 3; k++) begin fill_rand(k); relus[k] = 1'($urandom_range(0, 1)); end
    starts[0] = cyc + 2; starts[1] = starts[0] + 8; starts[2] = starts[0] + 14;
    rdy_mode = 2; rdy_until = cyc + 24; rows_seen = 0;
    run(3, 50, 1'b1);
    check("bp_rows", 64'(rows_seen), 64'd12);
    check("bp_ovf", 64'(bus.overflow), 64'd1);

    // Random traffic with random gaps and random consumer.
    for (int it = 0; it < 3; it++) begin
      for (int k = 0; k < 4; k++) begin fill_rand(k); relus[k] = 1'($urandom_range(0, 1)); end
      starts[0] = cyc + 2;
      for (int k = 1; k < 4; k++) starts[k] = starts[k-1] + $urandom_range(2, 12);
      rdy_mode = 1;
      run(4, starts[3] - cyc + 64, 1'b1);
    end

    // Reset while a second tile is in beat 2 and the first is waiting.
    for (int k = 0; k < 2; k++) begin fill_rand(k); relus[k] = 1'b0; end
    starts[0] = cyc + 2; starts[1] = starts[0] + 6; rdy_mode = 2; rdy_until = cyc + 1000;
    run(2, 10, 1'b0);
    mon_en = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    rstn = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_last", 64'(bus.out_last), 64'd0);
    check("mid_rst_ovf", 64'(bus.overflow), 64'd0);
    check("mid_rst_data", 64'(bus.out_data), 64'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    model_reset();
    mon_en = 1'b1;
    fill_rand(0); relus[0] = 1'b1; starts[0] = cyc + 2; rdy_mode = 0;
    run(1, 16, 1'b1);
    check("post_rst_rows", 64'(rows_seen), 64'd6);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
